// File: rtl/melody_pkg.sv
// Shared types, note frequencies and song tables for the melody sequencer.
// Tables are 16 deep; entries with dur_ms = 0 mark the end of a song.
package melody_pkg;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] dur_ms;
    } note_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    localparam logic [31:0] REST = 32'd0;
    localparam logic [31:0] C4   = 32'd262;
    localparam logic [31:0] D4   = 32'd294;
    localparam logic [31:0] E4   = 32'd330;
    localparam logic [31:0] F4   = 32'd349;
    localparam logic [31:0] G4   = 32'd392;
    localparam logic [31:0] A4   = 32'd440;
    localparam logic [31:0] B4   = 32'd494;
    localparam logic [31:0] C5   = 32'd523;
    localparam logic [31:0] D5   = 32'd587;
    localparam logic [31:0] E5   = 32'd659;
    localparam logic [31:0] F5   = 32'd698;
    localparam logic [31:0] G5   = 32'd784;
    localparam logic [31:0] A5   = 32'd880;
    localparam logic [31:0] B5   = 32'd988;

    localparam int SONG_LEN = 16;

    localparam note_t SONG [SONG_LEN] = '{
        '{A4,   16'd4}, '{B4, 16'd2}, '{REST, 16'd2}, '{C5, 16'd1},
        '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0},
        '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0},
        '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0}, '{REST, 16'd0}
    };

    // Every slot holds a real note, so playback only ends by running off the table.
    localparam note_t SCALE [SONG_LEN] = '{
        '{C4, 16'd1}, '{D4, 16'd1}, '{E4, 16'd1}, '{F4, 16'd1},
        '{G4, 16'd1}, '{A4, 16'd1}, '{B4, 16'd1}, '{C5, 16'd1},
        '{D5, 16'd1}, '{E5, 16'd1}, '{F5, 16'd1}, '{G5, 16'd1},
        '{A5, 16'd1}, '{B5, 16'd1}, '{REST, 16'd1}, '{C5, 16'd1}
    };

endpackage

// File: rtl/melody_player_rom.sv
// Combinational song table read; indices past the stored table read as the end marker.
module note_rom
    import melody_pkg::*;
#(
    parameter int NUM_NOTES = 16,
    parameter int SONG_SEL  = 0
) (
    input  logic [$clog2(NUM_NOTES)-1:0] idx,
    output note_t                        entry
);

    always_comb begin
        entry = '0;
        if (int'(idx) < SONG_LEN) begin
            entry = (SONG_SEL == 1) ? SCALE[idx] : SONG[idx];
        end
    end

endmodule

// File: rtl/melody_player.sv
// Song sequencer: walks the note table, times each note and articulation gap in ms,
// and drives freq/onOff of the tone generator with busy/done status.
module melody_player
    import melody_pkg::*;
#(
    parameter int FCLK      = 50000000,
    parameter int NUM_NOTES = 16,
    parameter int GAP_MS    = 20,
    parameter int SONG_SEL  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    output logic [31:0]                  freq,
    output logic                         onOff,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx
);

    localparam int IW  = $clog2(NUM_NOTES);
    localparam int CPM = FCLK / 1000;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);

    state_t        state, state_n;
    note_t         entry;
    logic [31:0]   freq_n;
    logic          onOff_n;
    logic          done_n;
    logic [IW-1:0] idx_n;
    logic [15:0]   ms_left, ms_left_n;
    logic [15:0]   gap_left, gap_left_n;
    logic [31:0]   presc, presc_n;
    logic          tick;
    logic          advance;
    logic          end_song;

    note_rom #(
        .NUM_NOTES (NUM_NOTES),
        .SONG_SEL  (SONG_SEL)
    ) u_rom (
        .idx   (note_idx),
        .entry (entry)
    );

    assign tick = (presc == 32'(CPM - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            freq     <= '0;
            onOff    <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
            ms_left  <= '0;
            gap_left <= '0;
            presc    <= '0;
        end else begin
            state    <= state_n;
            freq     <= freq_n;
            onOff    <= onOff_n;
            done     <= done_n;
            note_idx <= idx_n;
            ms_left  <= ms_left_n;
            gap_left <= gap_left_n;
            presc    <= presc_n;
        end
    end

    // Advance and end-of-song resolve in the same cycle as the last tick,
    // so a note costs (dur_ms + GAP_MS) * CPM cycles plus the one LOAD cycle.
    always_comb begin
        state_n    = state;
        freq_n     = freq;
        onOff_n    = onOff;
        done_n     = 1'b0;
        idx_n      = note_idx;
        ms_left_n  = ms_left;
        gap_left_n = gap_left;
        presc_n    = presc;
        advance    = 1'b0;
        end_song   = 1'b0;

        case (state)
            IDLE: begin
                freq_n  = '0;
                onOff_n = 1'b0;
                if (start && !stop) begin
                    state_n = LOAD;
                    idx_n   = '0;
                end
            end
            LOAD: begin
                if (entry.dur_ms == 16'd0) begin
                    end_song = 1'b1;
                end else begin
                    freq_n    = entry.freq;
                    onOff_n   = (entry.freq != 32'd0);
                    ms_left_n = entry.dur_ms;
                    presc_n   = '0;
                    state_n   = PLAY;
                end
            end
            PLAY: begin
                presc_n = tick ? 32'd0 : presc + 32'd1;
                if (tick) begin
                    ms_left_n = ms_left - 16'd1;
                    if (ms_left == 16'd1) begin
                        onOff_n = 1'b0;
                        if (GAP_MS == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_n    = GAP;
                            gap_left_n = 16'(GAP_MS);
                            presc_n    = '0;
                        end
                    end
                end
            end
            GAP: begin
                presc_n = tick ? 32'd0 : presc + 32'd1;
                if (tick) begin
                    gap_left_n = gap_left - 16'd1;
                    if (gap_left == 16'd1) begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (note_idx == LAST_IDX) begin
                end_song = 1'b1;
            end else begin
                idx_n   = note_idx + 1'b1;
                state_n = LOAD;
            end
        end

        if (end_song) begin
            if (loop) begin
                idx_n   = '0;
                state_n = LOAD;
            end else begin
                state_n    = IDLE;
                freq_n     = '0;
                onOff_n    = 1'b0;
                done_n     = 1'b1;
                ms_left_n  = '0;
                gap_left_n = '0;
                presc_n    = '0;
            end
        end

        // Abort has priority over everything else, including a simultaneous end-of-song.
        if (stop && state != IDLE) begin
            state_n    = IDLE;
            freq_n     = '0;
            onOff_n    = 1'b0;
            done_n     = 1'b0;
            ms_left_n  = '0;
            gap_left_n = '0;
            presc_n    = '0;
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player: short demo song on one instance, full 16-note table on another.
module tb_melody_player;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startA = 1'b0, stopA = 1'b0, loopA = 1'b0;
    logic        startB = 1'b0;
    logic [31:0] freqA, freqB;
    logic        onOffA, onOffB, busyA, busyB, doneA, doneB;
    logic [3:0]  idxA, idxB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    melody_player #(.FCLK(10000), .NUM_NOTES(16), .GAP_MS(1), .SONG_SEL(0)) u_song (
        .clk(clk), .reset(reset), .start(startA), .stop(stopA), .loop(loopA),
        .freq(freqA), .onOff(onOffA), .busy(busyA), .done(doneA), .note_idx(idxA)
    );

    melody_player #(.FCLK(10000), .NUM_NOTES(16), .GAP_MS(1), .SONG_SEL(1)) u_full (
        .clk(clk), .reset(reset), .start(startB), .stop(1'b0), .loop(1'b0),
        .freq(freqB), .onOff(onOffB), .busy(busyB), .done(doneB), .note_idx(idxB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive inputs, advance one rising edge, settle 1 time unit past it.
    task automatic applyStimulus(input logic st, input logic sp, input logic rs);
        startA = st;
        stopA  = sp;
        reset  = rs;
        @(posedge clk);
        #1;
    endtask

    // Length of the current run of identical {onOff, freq}, current sample included.
    task automatic countRun(output int n);
        logic        o;
        logic [31:0] f;
        o = onOffA;
        f = freqA;
        n = 0;
        while (onOffA === o && freqA === f && n < 1000) begin
            n++;
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int k;

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_freq", freqA, 0);
        checkOutput("rst_onoff", onOffA, 0);
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_done", doneA, 0);
        checkOutput("rst_idx", idxA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] basic song");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("load_busy", busyA, 1);
        checkOutput("load_onoff", onOffA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("n0_onoff", onOffA, 1);
        checkOutput("n0_freq", freqA, 440);
        checkOutput("n0_idx", idxA, 0);
        countRun(n); checkOutput("n0_len", n, 40);
        countRun(n); checkOutput("n0_gap_len", n, 11);
        checkOutput("n1_idx", idxA, 1);
        checkOutput("n1_freq", freqA, 494);
        countRun(n); checkOutput("n1_len", n, 20);
        countRun(n); checkOutput("n1_gap_len", n, 11);
        checkOutput("rest_idx", idxA, 2);
        checkOutput("rest_onoff", onOffA, 0);
        countRun(n); checkOutput("rest_len", n, 31);
        checkOutput("n3_idx", idxA, 3);
        checkOutput("n3_freq", freqA, 523);
        countRun(n); checkOutput("n3_len", n, 10);
        countRun(n); checkOutput("n3_gap_len", n, 11);
        checkOutput("eos_done", doneA, 1);
        checkOutput("eos_busy", busyA, 0);
        checkOutput("eos_freq", freqA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("eos_done_clr", doneA, 0);

        $display("[TB] looping");
        loopA = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        k = 0;
        while (idxA !== 4'd4 && k < 500) begin
            checkOutput("loop_no_done", doneA, 0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            k++;
        end
        checkOutput("loop_reach_eos", idxA, 4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("loop_idx0", idxA, 0);
        checkOutput("loop_done", doneA, 0);
        checkOutput("loop_busy", busyA, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("loop_freq", freqA, 440);
        checkOutput("loop_onoff", onOffA, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("loop_stop_busy", busyA, 0);
        checkOutput("loop_stop_done", doneA, 0);
        loopA = 1'b0;

        $display("[TB] stop mid-note");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("c15_onoff", onOffA, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stop_onoff", onOffA, 0);
        checkOutput("stop_freq", freqA, 0);
        checkOutput("stop_busy", busyA, 0);
        checkOutput("stop_done", doneA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stop_done_later", doneA, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("replay_idx", idxA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("replay_freq", freqA, 440);
        checkOutput("replay_onoff", onOffA, 1);

        $display("[TB] start/stop collisions");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        countRun(n); checkOutput("busy_start_len", n, 35);
        checkOutput("busy_start_idx", idxA, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_busy", busyA, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_busy", busyA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("both_busy_later", busyA, 0);
        checkOutput("both_onoff", onOffA, 0);

        $display("[TB] reset mid-gap");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (43) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_onoff", onOffA, 0);
        checkOutput("gap_freq", freqA, 440);
        checkOutput("gap_busy", busyA, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mrst_freq", freqA, 0);
        checkOutput("mrst_onoff", onOffA, 0);
        checkOutput("mrst_busy", busyA, 0);
        checkOutput("mrst_done", doneA, 0);
        checkOutput("mrst_idx", idxA, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_edge1", onOffA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_edge2", onOffA, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] full table");
        startB = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        startB = 1'b0;
        checkOutput("full_load_busy", busyB, 1);
        n = 0;
        while (doneB !== 1'b1 && n < 1000) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("full_done_seen", doneB, 1);
        checkOutput("full_cycles", n, 336);
        checkOutput("full_idx_last", idxB, 15);
        checkOutput("full_busy", busyB, 0);
        checkOutput("full_onoff", onOffB, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("full_done_clr", doneB, 0);
        checkOutput("full_no_wrap", idxB, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Sequencer stage directly upstream of the tone generator.
- Steps through a fixed song table of (frequency, duration) entries and drives the generator's freq/onOff inputs.
- Inserts a silent articulation gap after every note and reports busy/done to the top-level control (key/button logic).
- Song content comes from a constant table in the shared package, read through a small ROM sub-module.

Parameters:
- FCLK, 50000000: clock frequency in Hz; cycles per ms CPM = FCLK/1000, integer division, must be >= 2.
- NUM_NOTES, 16: song table depth, power of two; note_idx width = $clog2(NUM_NOTES).
- GAP_MS, 20: silent gap after each note in ms; 0 means no gap.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin playback from entry 0; sampled every cycle.
- stop  in  1  abort playback.
- loop  in  1  on end-of-song, 1 restarts at entry 0 and 0 finishes.
- freq  out  32  frequency in Hz to the tone generator.
- onOff  out  1  tone generator enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on a non-looping end-of-song.
- note_idx  out  $clog2(NUM_NOTES)  current table index.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, freq=0, onOff=0, busy=0, done=0, note_idx=0, all counters 0.
- Table entry: freq[31:0] plus dur_ms[15:0].
  - freq=0 is a rest: onOff stays 0 for the note's duration.
  - dur_ms=0 is the end-of-song marker.
- ms tick: prescaler counts 0..CPM-1 and pulses at CPM-1. It is cleared on entry to PLAY and to GAP, so every note and every gap is exactly N*CPM cycles.
- States:
  - IDLE: freq=0, onOff=0. start=1 -> LOAD with note_idx=0, busy=1 from the next cycle.
  - LOAD (1 cycle, ROM is combinational on note_idx):
    - dur_ms=0: end-of-song.
    - otherwise: latch freq, load ms_left=dur_ms, go to PLAY.
    - onOff = (freq != 0) from the PLAY entry cycle.
  - PLAY: decrement ms_left on each tick.
    - On a tick with ms_left=1: onOff=0, freq held.
    - Then GAP with gap_left=GAP_MS, or straight to the advance step if GAP_MS=0.
  - GAP: decrement gap_left on each tick; on a tick with gap_left=1, go to the advance step.
  - Advance step:
    - note_idx=NUM_NOTES-1: treat as end-of-song; the index does not wrap silently.
    - otherwise: note_idx+1, then LOAD.
  - End-of-song (loop is sampled in that cycle):
    - loop=1: note_idx=0, then LOAD; no done pulse.
    - loop=0: IDLE, freq=0, onOff=0, busy=0, and done=1 for exactly one cycle.
- stop=1 in any non-IDLE state -> IDLE on the next edge: onOff=0, freq=0, no done pulse, counters cleared.
- start while busy is ignored. start and stop together: stop wins.
- reset mid-note: all outputs return to reset values on the same edge.
- Timing: onOff rises 2 edges after start is sampled (IDLE->LOAD->PLAY). Non-last note period = (dur_ms+GAP_MS)*CPM + 1 cycles.
- Counters: ms_left and gap_left are 16 bit, compared for equality only, with no underflow.

Decomposition:
- Package melody_pkg:
  - note_t struct {logic [31:0] freq; logic [15:0] dur_ms;}
  - state enum {IDLE, LOAD, PLAY, GAP}
  - note frequency constants (C4..B5 in Hz, REST=0)
  - constant SONG array of note_t
- Sub-module note_rom: combinational read of SONG[idx]; entries beyond the song length return {0,0}, i.e. the end marker.
- melody_player holds the FSM, prescaler and counters.

Test Plan:
All scenarios use FCLK=10000 (CPM=10), GAP_MS=1, SONG = {440,4},{494,2},{0,2},{523,1},{0,0}.
- Basic song: start pulse, loop=0.
  - freq=440 with onOff=1 for exactly 40 cycles, then onOff=0 for 10, then 494 for 20.
  - Rest entry: freq=0 with onOff=0 for 20.
  - 523 for 10, then done=1 for one cycle; busy falls the same cycle.
- Looping: loop=1 through end-of-song -> no done pulse; freq returns to 440 one cycle after end-of-song, note_idx=0.
- Stop mid-note: stop at cycle 15 of the 440 note -> next edge onOff=0, freq=0, busy=0, done stays 0; a new start replays from entry 0.
- Start/stop collisions: start while busy -> ignored, note_idx and timing unchanged; start and stop together in IDLE -> stays IDLE.
- Reset mid-GAP: reset=1 for one cycle -> all outputs 0 on that edge and state IDLE; start afterwards gives onOff rising 2 edges later.
- Full table: all 16 entries non-zero -> end-of-song after note_idx=15, with no wrap to 0 when loop=0.
